// File: rtl/neurram_serial_pkg.sv
// Shared definitions for the neurram serial readback/programming paths:
// FSM encoding, default geometry and counter-width helper.
package neurram_serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_PUSH,
        ST_CS_HOLD
    } rd_state_e;

    localparam int DEF_WORD_W  = 32;
    localparam int DEF_CLK_DIV = 5;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. A write into a full FIFO is
// accepted only when a read pops in the same cycle.
module sync_fifo_fwft import neurram_serial_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = cnt_w(DEPTH - 1);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_wr, do_rd;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        cnt_d = cnt_q + CW'(do_wr) - CW'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the output is masked while empty.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/adc_daisy_readback.sv
// Daisy-chain ADC readback master: frames sck/cs_b, shifts in MSB-first
// words from the chain and queues them for the host end-point.
module adc_daisy_readback import neurram_serial_pkg::*; #(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int CHAIN_LEN  = 4,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ep_rd_en,
    output logic [WORD_W-1:0] ep_dout,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              overflow,
    output logic              frame_done,
    output logic              rd_state_idle,
    output logic              adc_sck,
    output logic              adc_cs_b,
    input  logic              adc_sdo
);
    localparam int HP_W  = cnt_w(CLK_DIV - 1);
    localparam int BIT_W = cnt_w(WORD_W);
    localparam int WRD_W = cnt_w(CHAIN_LEN);

    rd_state_e         state_q, state_d;
    logic [HP_W-1:0]   hp_cnt_q, hp_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WRD_W-1:0]  word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              sck_q, sck_d, cs_b_q, cs_b_d, idle_q, idle_d;
    logic              frame_done_q, frame_done_d, overflow_q, overflow_d;
    logic              hp_wrap, push;

    always_comb begin
        state_d      = state_q;
        hp_cnt_d     = hp_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        shreg_d      = shreg_q;
        sck_d        = 1'b0;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        push         = 1'b0;
        hp_wrap      = (hp_cnt_q == HP_W'(CLK_DIV - 1));
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_CS_SETUP;
                    hp_cnt_d   = '0;
                    overflow_d = 1'b0;
                end
            end
            ST_CS_SETUP: begin
                hp_cnt_d = hp_wrap ? '0 : hp_cnt_q + 1'b1;
                if (hp_wrap) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                sck_d    = sck_q;
                hp_cnt_d = hp_wrap ? '0 : hp_cnt_q + 1'b1;
                if (hp_wrap && !sck_q) begin
                    // Capture on the same edge that raises sck.
                    sck_d     = 1'b1;
                    shreg_d   = {shreg_q[WORD_W-2:0], adc_sdo};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else if (hp_wrap) begin
                    sck_d = 1'b0;
                    if (bit_cnt_q == BIT_W'(WORD_W)) state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                push      = 1'b1;
                bit_cnt_d = '0;
                hp_cnt_d  = '0;
                if (fifo_full && !ep_rd_en) overflow_d = 1'b1;
                if (word_cnt_q == WRD_W'(CHAIN_LEN - 1)) begin
                    word_cnt_d = '0;
                    state_d    = ST_CS_HOLD;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_CS_HOLD: begin
                hp_cnt_d = hp_wrap ? '0 : hp_cnt_q + 1'b1;
                if (hp_wrap) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cs_b_d = (state_d == ST_IDLE);
        idle_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hp_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            shreg_q      <= '0;
            sck_q        <= 1'b0;
            cs_b_q       <= 1'b1;
            idle_q       <= 1'b1;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hp_cnt_q     <= hp_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            shreg_q      <= shreg_d;
            sck_q        <= sck_d;
            cs_b_q       <= cs_b_d;
            idle_q       <= idle_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign adc_sck       = sck_q;
    assign adc_cs_b      = cs_b_q;
    assign rd_state_idle = idle_q;
    assign frame_done    = frame_done_q;
    assign overflow      = overflow_q;

    sync_fifo_fwft #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (shreg_q),
        .rd_en   (ep_rd_en),
        .rd_data (ep_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_adc_daisy_readback.sv
// Bench for adc_daisy_readback: a default-geometry instance (A) and a short
// CLK_DIV=2 / CHAIN_LEN=1 / FIFO_DEPTH=4 instance (B), each fed by a chain model.
module tb_adc_daisy_readback;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic        a_rst, a_start, a_rd, a_sdo, a_empty, a_full, a_ovf, a_fd, a_idle, a_sck, a_cs_b;
    logic [31:0] a_dout;
    logic        b_rst, b_start, b_rd, b_sdo, b_empty, b_full, b_ovf, b_fd, b_idle, b_sck, b_cs_b;
    logic [31:0] b_dout;

    adc_daisy_readback #(.WORD_W(32), .CHAIN_LEN(4), .CLK_DIV(5), .FIFO_DEPTH(16)) dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .ep_rd_en(a_rd), .ep_dout(a_dout),
        .fifo_empty(a_empty), .fifo_full(a_full), .overflow(a_ovf), .frame_done(a_fd),
        .rd_state_idle(a_idle), .adc_sck(a_sck), .adc_cs_b(a_cs_b), .adc_sdo(a_sdo));

    adc_daisy_readback #(.WORD_W(32), .CHAIN_LEN(1), .CLK_DIV(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .ep_rd_en(b_rd), .ep_dout(b_dout),
        .fifo_empty(b_empty), .fifo_full(b_full), .overflow(b_ovf), .frame_done(b_fd),
        .rd_state_idle(b_idle), .adc_sck(b_sck), .adc_cs_b(b_cs_b), .adc_sdo(b_sdo));

    // Chain models: a bit stream indexed by completed sck falls in the frame.
    logic [31:0] a_frame [4];
    logic [31:0] b_frame;
    int a_idx = 0;
    int b_idx = 0;
    assign a_sdo = (a_idx < 128) ? a_frame[a_idx / 32][31 - (a_idx % 32)] : 1'b0;
    assign b_sdo = (b_idx < 32) ? b_frame[31 - b_idx] : 1'b0;

    int a_rises = 0, a_hi_bad = 0, a_hi_run = 0, a_len = 0, a_last_len = 0, a_fd_cnt = 0, a_fd_bad = 0;
    int b_rises = 0, b_hi_bad = 0, b_hi_run = 0, b_len = 0, b_last_len = 0, b_fd_cnt = 0, b_fd_bad = 0;
    logic a_psck = 1'b0, a_pcs = 1'b1, b_psck = 1'b0, b_pcs = 1'b1;

    always @(posedge clk) begin
        #1;
        if (a_sck && !a_psck) a_rises++;
        if (a_sck) a_hi_run++;
        else if (a_psck) begin if (a_hi_run != 5) a_hi_bad++; a_hi_run = 0; end
        if (a_cs_b === 1'b0) a_len++;
        else if (!a_pcs) begin a_last_len = a_len; a_len = 0; end
        if (a_fd) begin a_fd_cnt++; if (!(a_cs_b && !a_pcs)) a_fd_bad++; end
        if (a_cs_b) a_idx = 0; else if (a_psck && !a_sck) a_idx++;
        a_psck = a_sck; a_pcs = a_cs_b;
    end

    always @(posedge clk) begin
        #1;
        if (b_sck && !b_psck) b_rises++;
        if (b_sck) b_hi_run++;
        else if (b_psck) begin if (b_hi_run != 2) b_hi_bad++; b_hi_run = 0; end
        if (b_cs_b === 1'b0) b_len++;
        else if (!b_pcs) begin b_last_len = b_len; b_len = 0; end
        if (b_fd) begin b_fd_cnt++; if (!(b_cs_b && !b_pcs)) b_fd_bad++; end
        if (b_cs_b) b_idx = 0; else if (b_psck && !b_sck) b_idx++;
        b_psck = b_sck; b_pcs = b_cs_b;
    end

    // Reference model: words the chain delivered, in order, bounded by capacity.
    logic [31:0] a_q [$];
    logic [31:0] b_q [$];
    bit b_exp_ovf = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic a_pop_check();
        logic [31:0] e;
        if (a_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL a_pop_unexpected: got %0h expected no word", a_dout);
        end else begin
            e = a_q.pop_front();
            check("a_pop_data", a_dout, e);
        end
    endtask

    task automatic b_pop_check();
        logic [31:0] e;
        if (b_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL b_pop_unexpected: got %0h expected no word", b_dout);
        end else begin
            e = b_q.pop_front();
            check("b_pop_data", b_dout, e);
        end
    endtask

    task automatic a_frame_run(input logic [31:0] w [4], input bit busy, input int pop_pct,
                               input int exp_len, input int exp_rises);
        int r0, fd0, hb0;
        bit done;
        r0 = a_rises; fd0 = a_fd_cnt; hb0 = a_hi_bad; done = 1'b0;
        for (int i = 0; i < 4; i++) begin a_frame[i] = w[i]; a_q.push_back(w[i]); end
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check("a_cs_low_after_start", a_cs_b, 1'b0);
        for (int c = 0; c < 3000 && !done; c++) begin
            a_start = busy && (c == 600);
            a_rd = 1'b0;
            if (!a_empty && $urandom_range(99) < pop_pct) begin a_pop_check(); a_rd = 1'b1; end
            @(negedge clk);
            if (a_fd) done = 1'b1;
        end
        a_rd = 1'b0; a_start = 1'b0;
        check("a_frame_done_seen", done, 1'b1);
        check("a_frame_len", a_last_len, exp_len);
        check("a_sck_rises", a_rises - r0, exp_rises);
        check("a_sck_high_len_bad", a_hi_bad - hb0, 0);
        check("a_frame_done_pulses", a_fd_cnt - fd0, 1);
        check("a_frame_done_align_bad", a_fd_bad, 0);
        check("a_overflow", a_ovf, 1'b0);
        if (busy) begin
            repeat (30) @(negedge clk);
            check("a_no_second_frame", {a_cs_b, a_idle, a_sck}, 3'b110);
        end
    endtask

    task automatic a_drain();
        for (int c = 0; c < 64 && !a_empty; c++) begin
            a_pop_check(); a_rd = 1'b1;
            @(negedge clk);
            a_rd = 1'b0;
        end
        check("a_drain_empty", a_empty, 1'b1);
        check("a_words_missing", a_q.size(), 0);
    endtask

    task automatic b_frame_run(input logic [31:0] w, input bit pop_in_push);
        int r0, hb0, fd0, falls;
        bit done, popped;
        logic pm;
        r0 = b_rises; hb0 = b_hi_bad; fd0 = b_fd_cnt; falls = 0; done = 1'b0; popped = 1'b0; pm = 1'b0;
        b_frame = w;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        b_exp_ovf = 1'b0;
        check("b_ovf_cleared_by_start", b_ovf, 1'b0);
        for (int c = 0; c < 400 && !done; c++) begin
            b_rd = 1'b0;
            if (pm && !b_sck) falls++;
            pm = b_sck;
            if (pop_in_push && falls == 32 && !popped) begin
                popped = 1'b1;
                b_pop_check();
                b_rd = 1'b1;
            end
            @(negedge clk);
            if (b_fd) done = 1'b1;
        end
        b_rd = 1'b0;
        if (b_q.size() < 4) b_q.push_back(w); else b_exp_ovf = 1'b1;
        check("b_frame_done_seen", done, 1'b1);
        check("b_frame_len", b_last_len, 133);
        check("b_sck_rises", b_rises - r0, 32);
        check("b_sck_high_len_bad", b_hi_bad - hb0, 0);
        check("b_frame_done_pulses", b_fd_cnt - fd0, 1);
        check("b_overflow", b_ovf, b_exp_ovf);
        check("b_full", b_full, b_q.size() == 4);
    endtask

    task automatic b_drain();
        for (int c = 0; c < 16 && !b_empty; c++) begin
            b_pop_check(); b_rd = 1'b1;
            @(negedge clk);
            b_rd = 1'b0;
        end
        check("b_drain_empty", b_empty, 1'b1);
        check("b_words_missing", b_q.size(), 0);
    endtask

    typedef struct {
        logic [31:0] w [4];
        bit          busy;
        int          pop_pct;
        int          exp_len;
        int          exp_rises;
    } fvec_t;

    initial begin
        fvec_t vecs [3];
        logic [31:0] rw [4];
        int r0;
        vecs[0].w = '{32'hDEADBEEF, 32'h12345678, 32'h00000001, 32'hFFFFFFFF};
        vecs[0].busy = 1'b0; vecs[0].pop_pct = 0;   vecs[0].exp_len = 1294; vecs[0].exp_rises = 128;
        vecs[1].w = '{32'h00000000, 32'h80000000, 32'h7FFFFFFF, 32'hA5A5A5A5};
        vecs[1].busy = 1'b1; vecs[1].pop_pct = 30;  vecs[1].exp_len = 1294; vecs[1].exp_rises = 128;
        vecs[2].w = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
        vecs[2].busy = 1'b0; vecs[2].pop_pct = 100; vecs[2].exp_len = 1294; vecs[2].exp_rises = 128;

        a_rst = 1'b1; a_start = 1'b0; a_rd = 1'b0;
        b_rst = 1'b1; b_start = 1'b0; b_rd = 1'b0;
        for (int i = 0; i < 4; i++) a_frame[i] = '0;
        b_frame = '0;
        repeat (3) @(negedge clk);
        check("a_reset_pins", {a_cs_b, a_sck, a_idle, a_fd}, 4'b1010);
        check("a_reset_fifo", {a_empty, a_full, a_ovf}, 3'b100);
        check("a_reset_dout", a_dout, 0);
        check("b_reset_pins", {b_cs_b, b_sck, b_idle, b_fd}, 4'b1010);
        check("b_reset_fifo", {b_empty, b_full, b_ovf}, 3'b100);
        a_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);

        // Pop while empty must be ignored.
        a_rd = 1'b1;
        @(negedge clk);
        a_rd = 1'b0;
        check("a_rd_empty_flags", {a_empty, a_full, a_cs_b, a_idle}, 4'b1011);
        check("a_rd_empty_dout", a_dout, 0);

        for (int v = 0; v < 3; v++) begin
            a_frame_run(vecs[v].w, vecs[v].busy, vecs[v].pop_pct, vecs[v].exp_len, vecs[v].exp_rises);
            a_drain();
        end

        // Reset in the middle of the second word of a frame.
        for (int i = 0; i < 4; i++) a_frame[i] = $urandom;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (400) @(negedge clk);
        check("a_midframe_cs", a_cs_b, 1'b0);
        check("a_midframe_word_buffered", a_empty, 1'b0);
        a_rst = 1'b1;
        repeat (3) @(negedge clk);
        a_rst = 1'b0;
        check("a_rst_pins", {a_cs_b, a_sck, a_idle, a_fd}, 4'b1010);
        check("a_rst_fifo", {a_empty, a_full, a_ovf}, 3'b100);
        r0 = a_rises;
        repeat (100) @(negedge clk);
        check("a_rst_no_sck", a_rises - r0, 0);
        check("a_rst_stays_idle", {a_cs_b, a_idle}, 2'b11);

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 4; i++) rw[i] = $urandom;
            a_frame_run(rw, 1'b0, 20, 1294, 128);
        end
        a_drain();

        b_frame_run(32'hA5C30F96, 1'b0);
        b_drain();
        for (int f = 0; f < 8; f++) b_frame_run($urandom, 1'b0);
        b_frame_run($urandom, 1'b1);
        b_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/adc_daisy_readback.md
# adc_daisy_readback

Serial readback master for daisy-chained ADC/DAC devices: generates the SPI-style `sck`/`cs_b` frame, captures MSB-first data from the chain's `sdo`, and buffers each 32-bit word for the host end-point. It is the receive-side counterpart to the daisy-chain DAC programming path and sits between the host end-point logic and the chip's serial output pins. It runs entirely in one clock domain with a divided serial clock.

## Interface
- `WORD_W`, 32: bits per device word.
- `CHAIN_LEN`, 4: words per frame (devices in chain), ≥1.
- `CLK_DIV`, 5: `clk` cycles per `sck` half-period, ≥2.
- `FIFO_DEPTH`, 16: output buffer depth in words, power of two.

- `clk` in 1: system clock, 100 MHz; single clock for the block.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin one frame; sampled only in IDLE.
- `ep_rd_en` in 1: pop one word from the buffer.
- `ep_dout` out WORD_W: head-of-buffer word, valid whenever `fifo_empty`=0 (first-word-fall-through).
- `fifo_empty` out 1: buffer empty.
- `fifo_full` out 1: buffer holds FIFO_DEPTH words.
- `overflow` out 1: sticky, a captured word was dropped.
- `frame_done` out 1: one-cycle pulse at frame end.
- `rd_state_idle` out 1: high in IDLE.
- `adc_sck` out 1: serial clock, idle low.
- `adc_cs_b` out 1: chip select, active low, idle high.
- `adc_sdo` in 1: serial data from chain, MSB first.

## Operation
- States: IDLE, CS_SETUP, SHIFT, PUSH, CS_HOLD.
- IDLE: `cs_b`=1, `sck`=0, `rd_state_idle`=1. `start`=1 → CS_SETUP; clears `overflow`.
- CS_SETUP: `cs_b`=0, `sck`=0 for CLK_DIV cycles → SHIFT.
- SHIFT: half-period counter counts 0..CLK_DIV-1; `sck` toggles at each wrap, starting low. On each cycle where `sck` goes 0→1, `adc_sdo` is shifted into bit 0 of the shift register (left shift) and the bit counter increments. After the WORD_W-th rising edge and its full high half-period, `sck` returns low and the FSM enters PUSH.
- PUSH (1 cycle, `sck`=0, `cs_b`=0): write the shift register to the buffer; increment the word counter; if words < CHAIN_LEN → SHIFT (bit counter cleared), else → CS_HOLD.
- CS_HOLD: `cs_b`=0, `sck`=0 for CLK_DIV cycles, then → IDLE with `frame_done`=1 on the transition cycle.
- Buffer push is accepted if not full, or if full and `ep_rd_en` pops in the same cycle. Otherwise the word is dropped, `overflow` is set, and the frame continues unchanged.
- `ep_rd_en` while empty: ignored. Pop and push in the same cycle: count unchanged.
- `start` outside IDLE: ignored. Frames are never aborted except by `rst`.
- `rst` at any time (including mid-frame): state IDLE, all counters 0, shift register 0, buffer emptied, `overflow`=0. Outputs: `cs_b`=1, `sck`=0, `frame_done`=0, `rd_state_idle`=1, `fifo_empty`=1, `fifo_full`=0, `ep_dout`=0.

## Timing
- All outputs are registered. `sck` and `cs_b` are driven from flops; no combinational clock gating.
- `start` high at edge n → `cs_b` low from cycle n+1.
- `sck` period = 2·CLK_DIV clk cycles (100 ns at defaults).
- Frame length (`cs_b` low) = 2·CLK_DIV + CHAIN_LEN·(2·WORD_W·CLK_DIV + 1) cycles. Defaults: 10 + 4·321 = 1294.
- First captured bit is the value of `adc_sdo` at the first `sck` rising edge. The chain device is expected to update on the falling edge.
- A word is visible on `ep_dout`/`fifo_empty` one cycle after its PUSH cycle.
- `frame_done` is asserted one cycle after the last CS_HOLD cycle, coincident with `cs_b` returning high.

## Structure
- Shared package `neurram_serial_pkg`: FSM state encoding, default WORD_W/CLK_DIV values, and a shared bit-counter width function.
- Sub-module `sync_fifo_fwft`: single-clock FWFT FIFO with parameterised width and depth, `full`/`empty` outputs, and a simultaneous read/write rule matching the push-acceptance rule above.
- The top level holds the FSM, the half-period/bit/word counters, and the shift register.

## Test plan
- Reset/idle: hold `rst` 3 cycles mid-frame → `cs_b`=1, `sck`=0, `fifo_empty`=1, `overflow`=0 on the next cycle; no further `sck` edges.
- Single frame: `sdo` model returns 0xDEADBEEF, 0x12345678, 0x00000001, 0xFFFFFFFF → 4 words read in that order; `frame_done` pulses once, 1294 cycles after `cs_b` falls.
- Timing check: CLK_DIV=2, CHAIN_LEN=1 → exactly 32 `sck` rising edges, each high for 2 cycles; `cs_b` low for 4 + 129 = 133 cycles.
- Overflow: FIFO_DEPTH=4, run 2 frames with no reads → first 4 words kept, last 4 dropped, `overflow`=1; next `start` clears it.
- Full with pop: buffer full, `ep_rd_en`=1 in the PUSH cycle → new word accepted, `overflow` stays 0, count stays 4.
- `start` while busy, and `ep_rd_en` while empty → no state change and no spurious data.
